// File: rtl/ap_unsi_wall_pipe.sv
// ap_unsi_wall_pipe: 3-stage unsigned Wallace multiplier.
// Per-beat exact or column-truncated mode, valid/ready on both sides.
module ap_unsi_wall_pipe #(
  parameter int DW    = 12,
  parameter int TRUNC = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [DW-1:0]   muld,
  input  logic [DW-1:0]   mulr,
  input  logic            apx,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [2*DW-1:0] res,
  output logic            res_apx
);
  localparam int PW = 2 * DW;

  function automatic int rows_at(int l);
    int r;
    r = DW;
    for (int k = 0; k < l; k++) r = 2 * (r / 3) + r % 3;
    return r;
  endfunction

  function automatic int n_lv();
    int r;
    int n;
    r = DW;
    n = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + r % 3;
      n++;
    end
    return n;
  endfunction

  localparam int NLV = n_lv();

  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic          a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [DW-1:0] pp_q [DW];
  logic [DW-1:0] pp_d [DW];
  logic [PW-1:0] sum_q, sum_d, cry_q, cry_d;
  logic [PW-1:0] res_q, res_d;
  logic          en, ld1, ld2, ld3;

  // One global enable: a stalled output freezes every stage.
  always_comb begin
    en  = ~(v3_q & ~out_rdy);
    ld1 = en & in_vld;
    ld2 = en & v1_q;
    ld3 = en & v2_q;
  end

  assign in_rdy  = en;
  assign out_vld = v3_q;
  assign res     = res_q;
  assign res_apx = a3_q;

  always_comb begin
    for (int i = 0; i < DW; i++) begin
      pp_d[i] = pp_q[i];
      for (int j = 0; j < DW; j++)
        if (ld1)
          pp_d[i][j] = muld[j] & mulr[i]
                     & ~(apx & (i + j < TRUNC));
    end
  end

  // Row-form Wallace tree: 3:2 full-adder layers until two rows remain.
  logic [PW-1:0] lv [NLV+1][DW];

  for (genvar r = 0; r < DW; r++) begin : g_l0
    assign lv[0][r] = PW'(pp_q[r]) << r;
  end

  for (genvar l = 0; l < NLV; l++) begin : g_lv
    localparam int R  = rows_at(l);
    localparam int G  = R / 3;
    localparam int RN = rows_at(l + 1);
    for (genvar g = 0; g < G; g++) begin : g_fa
      logic [PW-1:0] a, b, c;
      assign a = lv[l][3*g];
      assign b = lv[l][3*g+1];
      assign c = lv[l][3*g+2];
      assign lv[l+1][2*g]   = a ^ b ^ c;
      assign lv[l+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
    end
    for (genvar p = 0; p < R % 3; p++) begin : g_pass
      assign lv[l+1][2*G+p] = lv[l][3*G+p];
    end
    for (genvar z = RN; z < DW; z++) begin : g_zero
      assign lv[l+1][z] = '0;
    end
  end

  always_comb begin
    v1_d  = en ? in_vld : v1_q;
    a1_d  = ld1 ? apx : a1_q;
    v2_d  = en ? v1_q : v2_q;
    a2_d  = ld2 ? a1_q : a2_q;
    sum_d = ld2 ? lv[NLV][0] : sum_q;
    cry_d = ld2 ? lv[NLV][1] : cry_q;
    v3_d  = en ? v2_q : v3_q;
    a3_d  = ld3 ? a2_q : a3_q;
    res_d = ld3 ? sum_q + cry_q : res_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      a1_q  <= 1'b0;
      a2_q  <= 1'b0;
      a3_q  <= 1'b0;
      sum_q <= '0;
      cry_q <= '0;
      res_q <= '0;
      for (int i = 0; i < DW; i++) pp_q[i] <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      a3_q  <= a3_d;
      sum_q <= sum_d;
      cry_q <= cry_d;
      res_q <= res_d;
      for (int i = 0; i < DW; i++) pp_q[i] <= pp_d[i];
    end
  end
endmodule

// File: tb/tb_ap_unsi_wall_pipe.sv
// tb_ap_unsi_wall_pipe: directed table, random stream, stall and reset
// sequences, scoreboarded against a row-sum reference model.
module tb_ap_unsi_wall_pipe;
  localparam int DW    = 12;
  localparam int TRUNC = 9;

  logic            clk;
  logic            rst;
  logic            in_vld;
  logic            in_rdy;
  logic [DW-1:0]   muld;
  logic [DW-1:0]   mulr;
  logic            apx;
  logic            out_vld;
  logic            out_rdy;
  logic [2*DW-1:0] res;
  logic            res_apx;

  ap_unsi_wall_pipe #(.DW(DW), .TRUNC(TRUNC)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .muld(muld), .mulr(mulr), .apx(apx),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .res(res), .res_apx(res_apx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*DW-1:0] r;
    logic            a;
  } exp_t;

  typedef struct {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic            x;
    logic [2*DW-1:0] e;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sbq[$];
  int   out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Each multiplier bit adds its shifted multiplicand row; in
  // approximate mode the row loses every bit below column TRUNC.
  function automatic logic [2*DW-1:0] model(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic x);
    longint unsigned acc;
    longint unsigned mask;
    mask = ~((64'd1 << TRUNC) - 64'd1);
    if (!x) acc = 64'(a) * 64'(b);
    else begin
      acc = 0;
      for (int i = 0; i < DW; i++)
        if (b[i]) acc += (64'(a) << i) & mask;
    end
    return acc[2*DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (rst) sbq.delete();
    else begin
      if (in_vld && in_rdy) begin
        exp_t e;
        e.r = model(muld, mulr, apx);
        e.a = apx;
        sbq.push_back(e);
      end
      if (out_vld && out_rdy) begin
        out_cyc.push_back(cyc);
        if (sbq.size() == 0) chk("sb_extra_beat", 1, 0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_res", res, e.r);
          chk("sb_res_apx", res_apx, e.a);
        end
      end
    end
  end

  // Entered at posedge+1; returns at accept edge +1 with in_vld low.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic x);
    bit ok;
    ok = 0;
    muld = a; mulr = b; apx = x; in_vld = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    in_vld = 1'b0;
  endtask

  task automatic send_lat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic x, input logic [2*DW-1:0] e);
    send(a, b, x);
    chk("lat_c1_vld", out_vld, 0);
    @(posedge clk); #1;
    chk("lat_c2_vld", out_vld, 0);
    @(posedge clk); #1;
    chk("lat_c3_vld", out_vld, 1);
    chk("lat_res", res, e);
    chk("lat_res_apx", res_apx, x);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", sbq.size(), 0);
  endtask

  vec_t            vt[8];
  int              n0;
  logic [2*DW-1:0] r0;
  logic            a0;

  initial begin
    vt[0] = '{12'd4095, 12'd4095, 1'b0, 24'd16769025};
    vt[1] = '{12'd4095, 12'd4095, 1'b1, 24'd16764928};
    vt[2] = '{12'd512,  12'd1,    1'b1, 24'd512};
    vt[3] = '{12'd256,  12'd1,    1'b1, 24'd0};
    vt[4] = '{12'd3,    12'd3,    1'b1, 24'd0};
    vt[5] = '{12'd512,  12'd1,    1'b0, 24'd512};
    vt[6] = '{12'd256,  12'd1,    1'b0, 24'd256};
    vt[7] = '{12'd3,    12'd3,    1'b0, 24'd9};

    rst = 1'b1; in_vld = 1'b0; muld = '0; mulr = '0;
    apx = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_res_apx", res_apx, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;

    foreach (vt[i]) send_lat(vt[i].a, vt[i].b, vt[i].x, vt[i].e);

    n0 = out_cyc.size();
    for (int k = 0; k < 100; k++)
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           k[0]);
    drain();
    chk("stream_count", out_cyc.size() - n0, 100);
    if (out_cyc.size() >= n0 + 100)
      chk("stream_span", out_cyc[n0+99] - out_cyc[n0], 99);

    n0 = out_cyc.size();
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++)
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)));
    chk("bp_out_vld", out_vld, 1);
    r0 = res; a0 = res_apx;
    muld = 12'd1234; mulr = 12'd777; apx = 1'b1; in_vld = 1'b1;
    repeat (5) begin
      #1;
      chk("bp_in_rdy", in_rdy, 0);
      chk("bp_hold_vld", out_vld, 1);
      chk("bp_hold_res", res, r0);
      chk("bp_hold_apx", res_apx, a0);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    send(12'd1234, 12'd777, 1'b1);
    drain();
    chk("bp_count", out_cyc.size() - n0, 4);

    for (int k = 0; k < 3; k++)
      send(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           1'($urandom_range(0, 1)));
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_res", res, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_stale", out_vld, 0);
    end
    send_lat(12'd2049, 12'd3001, 1'b1, model(12'd2049, 12'd3001, 1'b1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
